// File: rtl/crash_grid_pkg.sv
// crash_grid shared definitions: check sequencer states, direction bit
// indices into the crash/hit vectors, default playfield geometry and a
// helper that sizes the block-map index.
package crash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHK_L = 3'd1,
    ST_CHK_R = 3'd2,
    ST_CHK_U = 3'd3,
    ST_CHK_D = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Bit positions inside the 4-bit {left, right, up, down} vectors.
  localparam int DIR_L = 3;
  localparam int DIR_R = 2;
  localparam int DIR_U = 1;
  localparam int DIR_D = 0;

  // Default geometry of the 640x480 playfield.
  localparam int DEF_COLS      = 20;
  localparam int DEF_ROWS      = 4;
  localparam int DEF_BLK_SHIFT = 5;
  localparam int DEF_BALL_R    = 10;
  localparam int DEF_PROBE_OFS = 26;
  localparam int DEF_SLD_HW    = 50;
  localparam int DEF_SLD_HH    = 20;
  localparam int DEF_SCR_W     = 640;
  localparam int DEF_SCR_H     = 480;
  localparam int DEF_SCORE_W   = 16;

  // Index width for an n-entry map; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/crash_grid_probe.sv
// crash_probe: combinational probe-point generator. Offsets the ball centre
// by PROBE_OFS in the requested direction (11-bit two's complement), converts
// the point to a block column/row and returns the row-major map index plus a
// flag telling whether the point lies inside the block map.
module crash_probe
  import crash_pkg::*;
#(
  parameter int COLS      = DEF_COLS,
  parameter int ROWS      = DEF_ROWS,
  parameter int BLK_SHIFT = DEF_BLK_SHIFT,
  parameter int PROBE_OFS = DEF_PROBE_OFS,
  parameter int IDX_W     = idx_width(DEF_ROWS * DEF_COLS)
) (
  input  logic [9:0]       ball_x,
  input  logic [9:0]       ball_y,
  input  logic [1:0]       dir,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [10:0] px_s;
  logic [10:0] py_s;
  logic [10:0] col_s;
  logic [10:0] row_s;

  // Probe point, its block coordinates and the in-map decision.
  always_comb begin
    px_s = {1'b0, ball_x};
    py_s = {1'b0, ball_y};
    case (dir)
      2'(DIR_L): px_s = {1'b0, ball_x} - 11'(PROBE_OFS);
      2'(DIR_R): px_s = {1'b0, ball_x} + 11'(PROBE_OFS);
      2'(DIR_U): py_s = {1'b0, ball_y} - 11'(PROBE_OFS);
      2'(DIR_D): py_s = {1'b0, ball_y} + 11'(PROBE_OFS);
      default:   px_s = {1'b0, ball_x};
    endcase
    col_s = px_s >> BLK_SHIFT;
    row_s = py_s >> BLK_SHIFT;
    // Bit 10 set means the point went negative (off the left/top edge).
    valid = !px_s[10] && !py_s[10] &&
            (col_s < 11'(COLS)) && (row_s < 11'(ROWS));
    if (valid) begin
      idx = IDX_W'(row_s * 11'(COLS) + col_s);
    end else begin
      idx = {IDX_W{1'b0}};
    end
  end

endmodule

// File: rtl/crash_grid.sv
// crash_grid: frame-strobed collision engine for the brick-breaker game.
// On iFrame (in IDLE) it latches ball/slider positions and wall/slider
// contacts, probes left, right, up, down on successive cycles clearing any
// block hit, then reports the per-direction crash flags with a oDone pulse.
// Optional macro CRASH_SCORE_EN enables the saturating score counter;
// without it oScore is tied to zero.
module crash_grid
  import crash_pkg::*;
#(
  parameter int COLS      = DEF_COLS,
  parameter int ROWS      = DEF_ROWS,
  parameter int BLK_SHIFT = DEF_BLK_SHIFT,
  parameter int BALL_R    = DEF_BALL_R,
  parameter int PROBE_OFS = DEF_PROBE_OFS,
  parameter int SLD_HW    = DEF_SLD_HW,
  parameter int SLD_HH    = DEF_SLD_HH,
  parameter int SCR_W     = DEF_SCR_W,
  parameter int SCR_H     = DEF_SCR_H,
  parameter int SCORE_W   = DEF_SCORE_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iFrame,
  input  logic [9:0]           iBall_x,
  input  logic [9:0]           iBall_y,
  input  logic [9:0]           iSlider_x,
  input  logic [9:0]           iSlider_y,
  output logic [ROWS*COLS-1:0] oState_flag,
  output logic [3:0]           oCrash,
  output logic                 oDone,
  output logic                 oBusy,
  output logic [SCORE_W-1:0]   oScore,
  output logic                 oCleared
);

  localparam int MAP_W = ROWS * COLS;
  localparam int IDX_W = idx_width(MAP_W);

  state_e             state_r;
  logic [MAP_W-1:0]   map_r;
  logic [9:0]         bx_r;
  logic [9:0]         by_r;
  logic [3:0]         contact_r;
  logic [3:0]         hit_r;
  logic [3:0]         crash_r;
  logic               done_r;
  logic               busy_r;
  logic               cleared_r;

  logic [1:0]         probe_dir_s;
  logic               chk_s;
  logic [IDX_W-1:0]   probe_idx_s;
  logic               probe_valid_s;
  logic [MAP_W-1:0]   onehot_s;
  logic               hit_s;
  logic [3:0]         contact_s;
  logic [11:0]        x_s;
  logic [11:0]        y_s;
  logic [11:0]        sx_s;
  logic [11:0]        sy_s;
  logic               x_win_s;
  logic               y_win_s;

  crash_probe #(
    .COLS      (COLS),
    .ROWS      (ROWS),
    .BLK_SHIFT (BLK_SHIFT),
    .PROBE_OFS (PROBE_OFS),
    .IDX_W     (IDX_W)
  ) u_probe (
    .ball_x (bx_r),
    .ball_y (by_r),
    .dir    (probe_dir_s),
    .idx    (probe_idx_s),
    .valid  (probe_valid_s)
  );

  // Select the probe direction for the current check state.
  always_comb begin
    probe_dir_s = 2'(DIR_L);
    chk_s       = 1'b0;
    case (state_r)
      ST_CHK_L: begin probe_dir_s = 2'(DIR_L); chk_s = 1'b1; end
      ST_CHK_R: begin probe_dir_s = 2'(DIR_R); chk_s = 1'b1; end
      ST_CHK_U: begin probe_dir_s = 2'(DIR_U); chk_s = 1'b1; end
      ST_CHK_D: begin probe_dir_s = 2'(DIR_D); chk_s = 1'b1; end
      default:  begin probe_dir_s = 2'(DIR_L); chk_s = 1'b0; end
    endcase
  end

  // Block hit: valid probe landing on a block still present in the map.
  always_comb begin
    onehot_s = MAP_W'(1'b1) << probe_idx_s;
    hit_s    = chk_s && probe_valid_s && (|(map_r & onehot_s));
  end

  // Wall and slider contacts from the live inputs; all comparisons are
  // rearranged so both sides are sums and nothing can underflow.
  always_comb begin
    x_s  = {2'b00, iBall_x};
    y_s  = {2'b00, iBall_y};
    sx_s = {2'b00, iSlider_x};
    sy_s = {2'b00, iSlider_y};
    y_win_s = (sy_s + 12'(BALL_R) <= y_s + 12'(SLD_HH)) &&
              (y_s + 12'(BALL_R) <= sy_s + 12'(SLD_HH));
    x_win_s = (sx_s + 12'(BALL_R) <= x_s + 12'(SLD_HW)) &&
              (x_s + 12'(BALL_R) <= sx_s + 12'(SLD_HW));
    contact_s[DIR_L] = (x_s <= 12'(BALL_R)) ||
                       ((x_s == sx_s + 12'(SLD_HW + BALL_R)) && y_win_s);
    contact_s[DIR_R] = (x_s >= 12'(SCR_W - BALL_R)) ||
                       ((x_s + 12'(BALL_R + SLD_HW) == sx_s) && y_win_s);
    contact_s[DIR_U] = (y_s <= 12'(BALL_R)) ||
                       ((y_s == sy_s + 12'(SLD_HH + BALL_R)) && x_win_s);
    contact_s[DIR_D] = (y_s >= 12'(SCR_H - BALL_R)) ||
                       ((y_s + 12'(BALL_R + SLD_HH) == sy_s) && x_win_s);
  end

  // Check sequencer: capture, four probe cycles, report, back to idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      map_r     <= {MAP_W{1'b1}};
      bx_r      <= 10'd0;
      by_r      <= 10'd0;
      contact_r <= 4'd0;
      hit_r     <= 4'd0;
      crash_r   <= 4'd0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (iFrame) begin
            bx_r      <= iBall_x;
            by_r      <= iBall_y;
            contact_r <= contact_s;
            hit_r     <= 4'd0;
            busy_r    <= 1'b1;
            state_r   <= ST_CHK_L;
          end
        end
        ST_CHK_L, ST_CHK_R, ST_CHK_U, ST_CHK_D: begin
          if (hit_s) begin
            map_r              <= map_r & ~onehot_s;
            hit_r[probe_dir_s] <= 1'b1;
          end
          case (state_r)
            ST_CHK_L: state_r <= ST_CHK_R;
            ST_CHK_R: state_r <= ST_CHK_U;
            ST_CHK_U: state_r <= ST_CHK_D;
            default:  state_r <= ST_DONE;
          endcase
        end
        ST_DONE: begin
          crash_r <= contact_r | hit_r;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky board-cleared flag, one cycle behind the map going empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cleared_r <= 1'b0;
    end else begin
      cleared_r <= cleared_r | (map_r == {MAP_W{1'b0}});
    end
  end

`ifdef CRASH_SCORE_EN
  logic [SCORE_W-1:0] score_r;

  // Saturating count of destroyed blocks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      score_r <= {SCORE_W{1'b0}};
    end else if (hit_s && (score_r != {SCORE_W{1'b1}})) begin
      score_r <= score_r + SCORE_W'(1);
    end
  end

  assign oScore = score_r;
`else
  assign oScore = {SCORE_W{1'b0}};
`endif

  assign oState_flag = map_r;
  assign oCrash      = crash_r;
  assign oDone       = done_r;
  assign oBusy       = busy_r;
  assign oCleared    = cleared_r;

endmodule

// File: tb/tb_crash_grid.sv
// Directed testbench for crash_grid: default 20x4 instance plus a 2x1
// instance for the board-cleared case. Expected scores follow CRASH_SCORE_EN.
module tb_crash_grid;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        iframe = 1'b0;
  logic [9:0]  ball_x = 10'd0, ball_y = 10'd0, sld_x = 10'd0, sld_y = 10'd0;
  logic [79:0] map;
  logic [3:0]  crash;
  logic        done, busy, cleared;
  logic [15:0] score;

  logic        iframe2 = 1'b0;
  logic [9:0]  ball2_x = 10'd0, ball2_y = 10'd0;
  logic [1:0]  map2;
  logic [3:0]  crash2;
  logic        done2, busy2, cleared2;
  logic [15:0] score2;

  int n_total = 0;
  int n_bad   = 0;
  logic [79:0] exp_map;
  logic [15:0] exp_score;

  always #5 clk = ~clk;

  crash_grid dut (
    .clk (clk), .rst (rst), .iFrame (iframe),
    .iBall_x (ball_x), .iBall_y (ball_y),
    .iSlider_x (sld_x), .iSlider_y (sld_y),
    .oState_flag (map), .oCrash (crash), .oDone (done), .oBusy (busy),
    .oScore (score), .oCleared (cleared)
  );

  crash_grid #(.ROWS(1), .COLS(2)) dut2 (
    .clk (clk), .rst (rst), .iFrame (iframe2),
    .iBall_x (ball2_x), .iBall_y (ball2_y),
    .iSlider_x (10'd600), .iSlider_y (10'd400),
    .oState_flag (map2), .oCrash (crash2), .oDone (done2), .oBusy (busy2),
    .oScore (score2), .oCleared (cleared2)
  );

  task automatic check_val(input string tag, input logic [127:0] got,
                           input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Strobe one frame and step to the cycle after edge 5 (oDone high).
  task automatic run_frame(input logic [9:0] bx, input logic [9:0] by,
                           input logic [9:0] sx, input logic [9:0] sy);
    @(negedge clk);
    ball_x = bx; ball_y = by; sld_x = sx; sld_y = sy; iframe = 1'b1;
    @(posedge clk); #1 iframe = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_val("done_early", done, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check_val("done_pulse", done, 1'b1);
    check_val("busy_at_done", busy, 1'b0);
  endtask

  initial begin
    int last;
    int pulses;
    int done_seen;
`ifdef CRASH_SCORE_EN
    exp_score = 16'd4;
`else
    exp_score = 16'd0;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_map", map, {80{1'b1}});
    check_val("rst_crash", crash, 4'b0000);
    check_val("rst_done", done, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_score", score, 16'd0);
    check_val("rst_cleared", cleared, 1'b0);
    check_val("rst_map2", map2, 2'b11);
    rst = 1'b1;

    // Frame 1: ball (100,50) hits blocks 22, 23, 3, 43
    @(negedge clk);
    ball_x = 10'd100; ball_y = 10'd50; sld_x = 10'd600; sld_y = 10'd400;
    iframe = 1'b1;
    @(posedge clk); #1 iframe = 1'b0;
    @(negedge clk);
    check_val("f1_busy", busy, 1'b1);
    check_val("f1_map_chk_l", map, {80{1'b1}});
    @(posedge clk);
    @(negedge clk);
    exp_map = {80{1'b1}};
    exp_map[22] = 1'b0;
    check_val("f1_map_after_l", map, exp_map);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("f1_done_early", done, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check_val("f1_done", done, 1'b1);
    exp_map[23] = 1'b0; exp_map[3] = 1'b0; exp_map[43] = 1'b0;
    check_val("f1_map", map, exp_map);
    check_val("f1_crash", crash, 4'b1111);
    check_val("f1_score", score, exp_score);
    @(negedge clk);
    check_val("f1_done_drop", done, 1'b0);
    check_val("f1_crash_hold", crash, 4'b1111);

    // Frame 2: same ball, blocks already gone
    run_frame(10'd100, 10'd50, 10'd600, 10'd400);
    check_val("f2_crash", crash, 4'b0000);
    check_val("f2_score", score, exp_score);
    check_val("f2_map", map, exp_map);

    // Frame 3: ball resting on slider top edge
    run_frame(10'd300, 10'd440, 10'd300, 10'd470);
    check_val("f3_crash", crash, 4'b0001);
    check_val("f3_map", map, exp_map);

    // Frame 4: left wall, left probe negative
    run_frame(10'd5, 10'd200, 10'd600, 10'd400);
    check_val("f4_crash", crash, 4'b1000);
    check_val("f4_map", map, exp_map);
    check_val("f4_cleared", cleared, 1'b0);

    // iFrame held high: oDone every 6 cycles
    @(negedge clk);
    ball_x = 10'd320; ball_y = 10'd240; sld_x = 10'd600; sld_y = 10'd400;
    iframe = 1'b1;
    last = -1;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        pulses++;
        if (last >= 0) check_val("pulse_gap", 32'(i - last), 32'd6);
        last = i;
      end
    end
    iframe = 1'b0;
    check_val("pulse_count", 32'(pulses), 32'd5);
    check_val("pulse_first", 32'(last - 24), 32'd5);

    // Reset during CHK_U
    @(negedge clk);
    @(negedge clk);
    ball_x = 10'd200; ball_y = 10'd100; iframe = 1'b1;
    @(posedge clk); #1 iframe = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("mid_pre_clear", map[65], 1'b0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("mid_map", map, {80{1'b1}});
    check_val("mid_busy", busy, 1'b0);
    check_val("mid_score", score, 16'd0);
    rst = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check_val("mid_no_done", 32'(done_seen), 32'd0);

    // 2x1 map: left and right probes clear both blocks
    @(negedge clk);
    ball2_x = 10'd32; ball2_y = 10'd16; iframe2 = 1'b1;
    @(posedge clk); #1 iframe2 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("c_map_l", map2, 2'b10);
    @(posedge clk);
    @(negedge clk);
    check_val("c_map_r", map2, 2'b00);
    check_val("c_cleared_early", cleared2, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check_val("c_cleared", cleared2, 1'b1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_val("c_done", done2, 1'b1);
    check_val("c_crash", crash2, 4'b1100);
`ifdef CRASH_SCORE_EN
    check_val("c_score", score2, 16'd2);
`else
    check_val("c_score", score2, 16'd0);
`endif
    @(negedge clk);
    check_val("c_cleared_hold", cleared2, 1'b1);
    check_val("c_main_map", map, {80{1'b1}});

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
